// File: rtl/fir_cmem_bank.sv
// fir_cmem_bank: multi-bank FIR coefficient store, host CMEM port plus per-start frame streamer.
// Optional macro CMEM_PARITY_EN: per-word even parity, adds inj_perr input and perr output.
`default_nettype none

module fir_cmem_bank #(
   parameter int BITS       = 16,
   parameter int TAPS       = 64,
   parameter int ADDR_WIDTH = 6,
   parameter int BANKS      = 2,
   parameter int BANK_WIDTH = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  CEN,
   input  logic                  WEN,
   input  logic [ADDR_WIDTH-1:0] A,
   input  logic [BANK_WIDTH-1:0] BA,
   input  logic [BITS-1:0]       D,
   output logic [BITS-1:0]       Q,
   output logic                  wr_drop,
   input  logic                  swap_req,
   input  logic [BANK_WIDTH-1:0] swap_bank,
   output logic [BANK_WIDTH-1:0] act_bank,
   input  logic                  start,
   output logic                  busy,
   output logic                  c_valid,
   output logic [ADDR_WIDTH-1:0] c_idx,
   output logic [BITS-1:0]       c_data,
`ifdef CMEM_PARITY_EN
   input  logic                  inj_perr,
   output logic                  perr,
`endif
   output logic                  c_last
);

`ifdef CMEM_PARITY_EN
   localparam int WW = BITS + 1;
`else
   localparam int WW = BITS;
`endif
   localparam logic [ADDR_WIDTH-1:0] C_LAST  = ADDR_WIDTH'(TAPS - 1);
   localparam logic [BANK_WIDTH:0]   C_BANKS = BANKS[BANK_WIDTH:0];

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   logic [WW-1:0]         mem_q [BANKS][TAPS];
   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic [BANK_WIDTH-1:0] pend_bank_q, pend_bank_d;
   logic [BANK_WIDTH-1:0] act_bank_d;
   logic                  pend_q, pend_d;
   logic                  busy_d;
   logic                  swap_ok, wr_hit_act, wr_en, frame_end;
   logic [WW-1:0]         wr_word, rd_word;

   assign swap_ok    = swap_req && ({1'b0, swap_bank} < C_BANKS);
   assign wr_hit_act = busy && (BA == act_bank);
   assign wr_en      = !CEN && !WEN && !wr_hit_act && ({1'b0, BA} < C_BANKS);
   assign frame_end  = (state_q == S_RUN) && (cnt_q == C_LAST);
   assign rd_word    = mem_q[act_bank][cnt_q];
`ifdef CMEM_PARITY_EN
   assign wr_word    = {(^D) ^ inj_perr, D};
`else
   assign wr_word    = D;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      act_bank_d  = act_bank;
      pend_d      = pend_q;
      pend_bank_d = pend_bank_q;
      case (state_q)
         S_IDLE: begin
            // Bank change lands before a same-cycle start so that frame uses the new bank.
            if (swap_ok) act_bank_d = swap_bank;
            if (start && !busy) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
            if (swap_ok) begin
               pend_d      = 1'b1;
               pend_bank_d = swap_bank;
            end
            if (frame_end) begin
               state_d = S_IDLE;
               pend_d  = 1'b0;
               if (swap_ok)     act_bank_d = swap_bank;
               else if (pend_q) act_bank_d = pend_bank_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_RUN) || frame_end;
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[BA][A] <= wr_word;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         pend_q      <= 1'b0;
         pend_bank_q <= '0;
         act_bank    <= '0;
         busy        <= 1'b0;
         Q           <= '0;
         wr_drop     <= 1'b0;
         c_valid     <= 1'b0;
         c_idx       <= '0;
         c_data      <= '0;
         c_last      <= 1'b0;
`ifdef CMEM_PARITY_EN
         perr        <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
         pend_bank_q <= pend_bank_d;
         act_bank    <= act_bank_d;
         busy        <= busy_d;
         wr_drop     <= !CEN && !WEN && wr_hit_act;
         if (!CEN && WEN) Q <= mem_q[BA][A][BITS-1:0];
         c_valid     <= (state_q == S_RUN);
         c_last      <= frame_end;
         if (state_q == S_RUN) begin
            c_idx  <= cnt_q;
            c_data <= rd_word[BITS-1:0];
         end
`ifdef CMEM_PARITY_EN
         perr        <= (state_q == S_RUN) && (^rd_word);
`endif
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fir_cmem_bank.sv
// tb_fir_cmem_bank: scoreboard bench, input-driven reference model plus negedge monitor.
`default_nettype none

module tb_fir_cmem_bank;
   localparam int BITS = 16, TAPS = 64, AW = 6, BANKS = 2, BW = 1;

   logic clk = 1'b0;
   logic rst_n, CEN, WEN, swap_req, start, inj_perr;
   logic [AW-1:0] A;
   logic [BW-1:0] BA, swap_bank;
   logic [BITS-1:0] D;
   logic [BITS-1:0] Q, c_data;
   logic wr_drop, busy, c_valid, c_last;
   logic [BW-1:0] act_bank;
   logic [AW-1:0] c_idx;
`ifdef CMEM_PARITY_EN
   logic perr;
`endif

   always #5 clk = ~clk;

   fir_cmem_bank #(.BITS(BITS), .TAPS(TAPS), .ADDR_WIDTH(AW), .BANKS(BANKS), .BANK_WIDTH(BW)) dut (
      .clk(clk), .rst_n(rst_n), .CEN(CEN), .WEN(WEN), .A(A), .BA(BA), .D(D), .Q(Q),
      .wr_drop(wr_drop), .swap_req(swap_req), .swap_bank(swap_bank), .act_bank(act_bank),
      .start(start), .busy(busy), .c_valid(c_valid), .c_idx(c_idx), .c_data(c_data),
`ifdef CMEM_PARITY_EN
      .inj_perr(inj_perr), .perr(perr),
`endif
      .c_last(c_last)
   );

   typedef struct {int e; int idx; int data; bit last; bit pe;} sexp_t;
   typedef struct {int e; int val;} rexp_t;
   sexp_t sq[$];
   rexp_t rq[$];
   int    wq[$];

   int mem_m [BANKS][TAPS];
   bit bad_m [BANKS][TAPS];
   int act_m = 0, pb_m = 0, se_m = -1000, edge_n = 0, rst_edge = -1;
   bit pend_m = 0;
   int n_chk = 0, n_fail = 0;

   // Busy holds from the start edge through the cycle that shows the last tap.
   function automatic bit busy_after(int n);
      return (n >= se_m) && (n <= se_m + TAPS);
   endfunction

   task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, got, exp, edge_n);
      end
   endtask

   always @(posedge clk) begin
      bit b, run, fend;
      edge_n++;
      if (!rst_n) begin
         se_m = -1000; pend_m = 0; act_m = 0; rst_edge = edge_n;
         sq.delete(); rq.delete(); wq.delete();
      end else begin
         b    = busy_after(edge_n - 1);
         run  = (edge_n > se_m) && (edge_n <= se_m + TAPS);
         fend = (edge_n == se_m + TAPS);
         if (!CEN && !WEN) begin
            if (b && (int'(BA) == act_m)) wq.push_back(edge_n);
            else begin
               mem_m[BA][A] = int'(D);
               bad_m[BA][A] = inj_perr;
            end
         end else if (!CEN) begin
            rq.push_back('{edge_n, mem_m[BA][A]});
         end
         if (swap_req) begin
            if (run) begin pend_m = 1; pb_m = int'(swap_bank); end
            else act_m = int'(swap_bank);
         end
         if (fend && pend_m) begin act_m = pb_m; pend_m = 0; end
         if (start && !b) begin
            se_m = edge_n;
            for (int i = 0; i < TAPS; i++)
               sq.push_back('{edge_n + 1 + i, i, mem_m[act_m][i], i == TAPS - 1, bad_m[act_m][i]});
         end
      end
   end

   always @(negedge clk) begin
      bit exp_v, exp_drop;
      if (edge_n > 0) begin
         if (rst_edge == edge_n) begin
            chk("reset_outs", {21'd0, Q, wr_drop, act_bank, busy, c_valid, c_idx, c_data, c_last}, 64'd0);
`ifdef CMEM_PARITY_EN
            chk("reset_perr", {63'd0, perr}, 64'd0);
`endif
         end
         chk("busy", {63'd0, busy}, {63'd0, busy_after(edge_n)});
         chk("act_bank", {63'd0, act_bank}, 64'(act_m));
         while (wq.size() > 0 && wq[0] < edge_n) void'(wq.pop_front());
         exp_drop = (wq.size() > 0) && (wq[0] == edge_n);
         chk("wr_drop", {63'd0, wr_drop}, {63'd0, exp_drop});
         while (rq.size() > 0 && rq[0].e < edge_n) void'(rq.pop_front());
         if (rq.size() > 0 && rq[0].e == edge_n) begin
            chk("host_Q", {48'd0, Q}, 64'(rq[0].val));
            void'(rq.pop_front());
         end
         exp_v = (sq.size() > 0) && (sq[0].e == edge_n);
         chk("c_valid", {63'd0, c_valid}, {63'd0, exp_v});
         if (exp_v) begin
            if (c_valid) begin
               chk("c_idx", {58'd0, c_idx}, 64'(sq[0].idx));
               chk("c_data", {48'd0, c_data}, 64'(sq[0].data));
               chk("c_last", {63'd0, c_last}, {63'd0, sq[0].last});
`ifdef CMEM_PARITY_EN
               chk("perr", {63'd0, perr}, {63'd0, sq[0].pe});
`endif
            end
            void'(sq.pop_front());
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
      CEN = 1'b1; WEN = 1'b1; start = 1'b0; swap_req = 1'b0; inj_perr = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc();
   endtask

   task automatic wr(input int b, input int a, input int d);
      BA = BW'(b); A = AW'(a); D = BITS'(d); CEN = 1'b0; WEN = 1'b0;
      cyc();
   endtask

   task automatic rd(input int b, input int a);
      BA = BW'(b); A = AW'(a); CEN = 1'b0; WEN = 1'b1;
      cyc();
   endtask

   task automatic go();
      start = 1'b1;
      cyc();
   endtask

   task automatic swap(input int b);
      swap_req = 1'b1; swap_bank = BW'(b);
      cyc();
   endtask

   initial begin
      rst_n = 1'b0; CEN = 1'b1; WEN = 1'b1; A = '0; BA = '0; D = '0;
      swap_req = 1'b0; swap_bank = '0; start = 1'b0; inj_perr = 1'b0;
      idle(3);
      rst_n = 1'b1;
      idle(2);

      for (int i = 0; i < TAPS; i++) wr(0, i, i);
      for (int i = 0; i < TAPS; i++) wr(1, i, 1000 + i);
      rd(1, 5); rd(0, 63); rd(1, 0);
      wr(1, 50, 4242); rd(1, 50); wr(1, 50, 1050); rd(1, 50);
      idle(2);

      // Frame from bank0: dropped write to active bank, accepted write elsewhere, late swap.
      go();
      idle(4);
      wr(0, 3, 999);
      wr(1, 3, 7);
      idle(14);
      swap(1);
      idle(8);
      go();
      idle(50);
      go();
      idle(70);
      rd(0, 3);

      for (int k = 0; k < 1500; k++) begin
         int r;
         r = $urandom_range(0, 9);
         BA = BW'($urandom_range(0, BANKS - 1));
         A  = AW'($urandom_range(0, TAPS - 1));
         D  = BITS'($urandom_range(0, 65535));
         if (r < 4) begin CEN = 1'b0; WEN = 1'b0; end
         else if (r < 7) begin CEN = 1'b0; WEN = 1'b1; end
         start = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 29) == 0) begin
            swap_req  = 1'b1;
            swap_bank = BW'($urandom_range(0, BANKS - 1));
         end
         cyc();
      end
      idle(70);

      // Reset while the frame shows tap 30; bank contents must survive.
      for (int i = 0; i < TAPS; i++) wr(0, i, 3 * i + 11);
      go();
      idle(31);
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      idle(2);
      go();
      idle(70);

`ifdef CMEM_PARITY_EN
      BA = '0; A = AW'(10); D = BITS'(1234); CEN = 1'b0; WEN = 1'b0; inj_perr = 1'b1;
      cyc();
      go();
      idle(70);
`endif

      for (int w = 0; w < 200 && sq.size() > 0; w++) cyc();
      chk("stream_drain", 64'(sq.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1);
   end

endmodule

`default_nettype wire

// File: doc/fir_cmem_bank.md
Name: fir_cmem_bank

Overview:
Parametrised, multi-bank coefficient memory for the 16-bit / 64-tap FIR datapath.
- Host side: CMEM-style port with active-low CEN/WEN for loading and reading back coefficients in any bank.
- FIR ALU side: an autonomous sequencer streams one full coefficient set from the active bank per start.
- Bank switch: swaps are deferred to frame boundaries, so coefficients can be reloaded while filtering without glitches.

Parameters:
BITS, 16, coefficient word width
TAPS, 64, words per bank (filter length)
ADDR_WIDTH, 6, tap address width; must equal clog2(TAPS)
BANKS, 2, number of coefficient banks (>=2)
BANK_WIDTH, 1, bank select width; must equal clog2(BANKS)

Ports:
clk  in  1  single clock, all logic on posedge
rst_n  in  1  synchronous, active-low reset
CEN  in  1  host chip enable, active-low
WEN  in  1  host write enable, active-low (valid only with CEN=0)
A  in  ADDR_WIDTH  host tap address
BA  in  BANK_WIDTH  host bank address
D  in  BITS  host write data
Q  out  BITS  host read data
wr_drop  out  1  one-cycle pulse: host write rejected
swap_req  in  1  pulse: request active bank change
swap_bank  in  BANK_WIDTH  requested bank
act_bank  out  BANK_WIDTH  bank currently used by the streamer
start  in  1  pulse: stream one coefficient frame
busy  out  1  streamer running
c_valid  out  1  c_data/c_idx valid
c_idx  out  ADDR_WIDTH  tap index of c_data
c_data  out  BITS  coefficient
c_last  out  1  marks tap TAPS-1

Behaviour:
- Reset (rst_n=0 at posedge):
  - Q, wr_drop, act_bank, busy, c_valid, c_idx, c_data, c_last = 0.
  - Swap pending flag cleared; FSM forced to IDLE, including mid-stream (frame aborted, no c_last).
  - Memory array is not reset; contents are retained across reset.
- Host write: at posedge with CEN=0, WEN=0:
  - mem[BA][A] <= D.
  - Exception: if busy=1 and BA==act_bank, the write is dropped and wr_drop=1 for the next cycle.
  - Writes to inactive banks are always accepted.
- Host read: at posedge with CEN=0, WEN=1, Q <= mem[BA][A]. Latency 1 cycle. Q holds its value when CEN=1 or on a write.
- Same-address read-after-write: a read in cycle N+1 returns data written in cycle N.
- FSM:
  - States: IDLE, RUN.
  - IDLE -> RUN on start=1.
  - RUN -> IDLE at the edge that presents c_last.
  - start while busy=1 is ignored; no queueing.
- Stream timing:
  - Start accepted at edge E.
  - busy=1 from E through the cycle presenting c_last.
  - c_valid=1 for exactly TAPS consecutive cycles, beginning one cycle after E.
  - c_idx runs 0..TAPS-1; c_data = mem[act_bank][c_idx]; c_last=1 only with c_idx=TAPS-1.
  - busy=0 in the cycle after c_last. A start in that cycle is accepted (gap of one idle cycle minimum between frames).
- Swap:
  - swap_req with swap_bank >= BANKS is ignored.
  - IDLE: act_bank <= swap_bank at the same edge.
  - RUN: the request is latched as pending and applied at the edge presenting c_last. A newer request overwrites the pending one.
  - swap_req and start in the same IDLE cycle: the new bank takes effect first, and that frame streams from the new bank.
- Host port and streamer operate concurrently with no stalls; the memory model has one write port and two read ports.

Optional Feature:
CMEM_PARITY_EN:
- Defined:
  - Each word stores an extra even-parity bit computed from D on write.
  - Adds output perr (1 bit), registered alongside c_valid. perr=1 when the streamed word's parity mismatches.
  - perr is reset to 0.
  - Adds input `inj_perr` (test only): when 1 during a write, the stored parity bit is inverted.
- Undefined: no parity storage, no perr or inj_perr ports.

Test Plan:
- Load bank0 with 0..63 and bank1 with 1000..1063 via the host port; read back bank1 addr 5 -> Q=1005, one cycle after the read edge.
- act_bank=0, start pulse:
  - c_valid high for 64 cycles; c_idx 0..63; c_data 0..63.
  - c_last only at idx 63; busy drops the following cycle.
- swap_req(bank 1) at idx 20 of a frame:
  - act_bank stays 0 until the c_last edge, then becomes 1.
  - Next frame streams 1000..1063.
- While streaming bank0, write bank0 addr 3 -> wr_drop pulses and mem unchanged. Write bank1 addr 3 = 7 -> accepted.
- rst_n=0 at idx 30:
  - All outputs 0 next cycle; no c_last.
  - After release, start streams bank0 intact from idx 0.
- CMEM_PARITY_EN: write addr 10 with inj_perr=1, then stream -> perr=1 only with c_idx=10.
